// File: rtl/rw_arbiter.sv
// Round-robin arbiter that shares one read/write register atom between NUM_REQ requesters.
// Optional per-requester grant counters are compiled in with RW_ARB_GRANT_CNT_EN.

`ifdef RW_ARB_GRANT_CNT_EN
module rw_arbiter_gcnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end

    assign o_cnt = r_cnt;
endmodule
`endif

module rw_arbiter #(
    parameter  int COUNT_WIDTH = 32,
    parameter  int NUM_REQ     = 4,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i__req_valid,
    input  logic [NUM_REQ-1:0]             i__req_sel,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt,
    input  logic [COUNT_WIDTH-1:0]         i__constant,
    output logic [NUM_REQ-1:0]             o__req_ready,
    output logic                           o__rsp_valid,
    input  logic                           i__rsp_ready,
    output logic [IDW-1:0]                 o__rsp_id,
    output logic [COUNT_WIDTH-1:0]         o__rsp_read,
    output logic [COUNT_WIDTH-1:0]         o__rsp_write
`ifdef RW_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]          o__grant_cnt
`endif
);
    localparam int CW = COUNT_WIDTH;

    logic                 w_adv;
    logic                 w_found;
    logic                 w_accept;
    logic [IDW-1:0]       w_winner;
    logic [IDW-1:0]       w_idx;
    logic [IDW-1:0]       w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant;
    logic [CW-1:0]        w_pkt [NUM_REQ];
    logic [CW-1:0]        w_new;

    logic [IDW-1:0]       r_ptr;
    logic [2:1]           r_vld_pipe;
    logic [IDW-1:0]       r_s1_id;
    logic                 r_s1_sel;
    logic [CW-1:0]        r_s1_pkt;
    logic [CW-1:0]        r_s1_const;
    logic [CW-1:0]        r_state;
    logic [IDW-1:0]       r_rsp_id;
    logic [CW-1:0]        r_rsp_read;
    logic [CW-1:0]        r_rsp_write;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_pkt
        assign w_pkt[k] = i__req_pkt[k*CW +: CW];
    end

    // The whole pipeline moves together; a held response freezes S1 and blocks new grants.
    assign w_adv = !r_vld_pipe[2] || i__rsp_ready;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i__req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant      = (!rst && w_adv && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
    assign w_accept     = |(i__req_valid & w_grant);
    assign w_ptr_nxt    = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_new        = r_s1_sel ? r_s1_pkt : r_s1_const;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_vld_pipe  <= '0;
            r_s1_id     <= '0;
            r_s1_sel    <= 1'b0;
            r_s1_pkt    <= '0;
            r_s1_const  <= '0;
            r_state     <= '0;
            r_rsp_id    <= '0;
            r_rsp_read  <= '0;
            r_rsp_write <= '0;
        end else if (w_adv) begin
            if (w_accept)
                r_ptr <= w_ptr_nxt;
            r_vld_pipe[1] <= w_accept;
            r_s1_id       <= w_winner;
            r_s1_sel      <= i__req_sel[w_winner];
            r_s1_pkt      <= w_pkt[w_winner];
            r_s1_const    <= i__constant;
            r_vld_pipe[2] <= r_vld_pipe[1];
            // Only this stage touches r_state, so read-old/write-new is atomic by construction.
            if (r_vld_pipe[1]) begin
                r_rsp_id    <= r_s1_id;
                r_rsp_read  <= r_state;
                r_rsp_write <= w_new;
                r_state     <= w_new;
            end
        end
    end

    assign o__req_ready = w_grant;
    assign o__rsp_valid = r_vld_pipe[2];
    assign o__rsp_id    = r_rsp_id;
    assign o__rsp_read  = r_rsp_read;
    assign o__rsp_write = r_rsp_write;

`ifdef RW_ARB_GRANT_CNT_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_gcnt
        rw_arbiter_gcnt u_gcnt (
            .clk   (clk),
            .rst   (rst),
            .i_inc (i__req_valid[k] & w_grant[k]),
            .o_cnt (o__grant_cnt[k*16 +: 16])
        );
    end
`endif
endmodule

// File: tb/tb_rw_arbiter.sv
// Scoreboard bench for rw_arbiter: a negedge monitor models grant order and the atom,
// pushes expected responses at accept and pops/compares them when the response is presented.
module tb_rw_arbiter;
    localparam int CW  = 32;
    localparam int NR  = 4;
    localparam int IDW = $clog2(NR);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  rd;
        logic [CW-1:0]  wr;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_sel;
    logic [NR*CW-1:0]  req_pkt;
    logic [CW-1:0]     cnst;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     rsp_read;
    logic [CW-1:0]     rsp_write;
`ifdef RW_ARB_GRANT_CNT_EN
    logic [NR*16-1:0]  grant_cnt;
`endif

    rw_arbiter #(.COUNT_WIDTH(CW), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i__req_valid (req_valid),
        .i__req_sel   (req_sel),
        .i__req_pkt   (req_pkt),
        .i__constant  (cnst),
        .o__req_ready (req_ready),
        .o__rsp_valid (rsp_valid),
        .i__rsp_ready (rsp_ready),
        .o__rsp_id    (rsp_id),
        .o__rsp_read  (rsp_read),
        .o__rsp_write (rsp_write)
`ifdef RW_ARB_GRANT_CNT_EN
        ,
        .o__grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // model state
    rsp_t          exp_q[$];
    rsp_t          rsp_log[$];
    int            grant_log[$];
    int            m_ptr = 0;
    logic [CW-1:0] m_state = '0;
    bit            m_s1 = 0;
    bit            m_s2 = 0;
    logic [NR-1:0] acc_mask = '0;
    logic [NR-1:0] oneshot = '0;

    initial forever begin
        bit            adv;
        int            w;
        int            k;
        logic [NR-1:0] exp_rdy;
        logic [CW-1:0] nv;
        rsp_t          e;
        @(negedge clk);
        acc_mask = '0;
        chk("rsp_valid", rsp_valid, m_s2);
        if (rst) begin
            chk("rdy_in_rst", req_ready, '0);
            m_s1 = 0; m_s2 = 0; m_ptr = 0; m_state = '0;
            exp_q.delete();
        end else begin
            adv = !m_s2 || rsp_ready;
            w = -1;
            exp_rdy = '0;
            if (adv) begin
                for (int i = 0; i < NR; i++) begin
                    k = (m_ptr + i) % NR;
                    if (w < 0 && req_valid[k]) w = k;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            if (m_s2 && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_read", rsp_read, e.rd);
                chk("rsp_write", rsp_write, e.wr);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    rsp_log.push_back('{id: rsp_id, rd: rsp_read, wr: rsp_write});
                end
            end
            if (w >= 0) begin
                nv = req_sel[w] ? req_pkt[w*CW +: CW] : cnst;
                exp_q.push_back('{id: IDW'(w), rd: m_state, wr: nv});
                m_state = nv;
                m_ptr = (w + 1) % NR;
                acc_mask = exp_rdy;
                grant_log.push_back(w);
            end
            if (adv) begin
                m_s2 = m_s1;
                m_s1 = (w >= 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc_mask & oneshot);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((req_valid != '0 || m_s1 || m_s2) && n < 30) begin
            cyc();
            n++;
        end
        chk({tag, "_drain_in_time"}, 64'(n < 30), 64'd1);
    endtask

    task automatic set_pkt(input int k, input logic s, input logic [CW-1:0] v);
        req_sel[k] = s;
        req_pkt[k*CW +: CW] = v;
    endtask

    initial begin
        logic [4*IDW-1:0] dummy;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        dummy = '0;
        rst = 1'b1; req_valid = '1; req_sel = '0; req_pkt = '0; cnst = '0; rsp_ready = 1'b1;

        // T1: reset with all requesters asserting
        cyc(); cyc();
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_read", rsp_read, 0);
        chk("t1_rsp_write", rsp_write, 0);
        rst = 1'b0;

        // T3: continuous round-robin
        set_pkt(0, 1'b1, 32'h1111_0000);
        set_pkt(1, 1'b0, 32'h2222_0000);
        set_pkt(2, 1'b1, 32'h3333_0000);
        set_pkt(3, 1'b1, 32'h4444_0000);
        cnst = 32'hA5A5_0000;
        grant_log.delete();
        repeat (6) cyc();
        chk("t1_first_grant", 64'(grant_log[0]), 0);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

        // T4: backpressure while full
        rsp_ready = 1'b0;
        repeat (5) cyc();
        rsp_ready = 1'b1;
        repeat (3) cyc();

        // T5: reset with S1/S2 both occupied
        rsp_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (3) cyc();
        chk("t5_no_rsp_after_flush", rsp_valid, 0);

        // T2: single write then read against a fresh state
        oneshot = '1;
        rsp_log.delete();
        set_pkt(1, 1'b1, 32'h1234_5678);
        req_valid = 4'b0010;
        drain("t2a");
        chk("t2a_id", rsp_log[$].id, 1);
        chk("t2a_read", rsp_log[$].rd, 0);
        chk("t2a_write", rsp_log[$].wr, 32'h1234_5678);
        set_pkt(2, 1'b0, 32'hDEAD_BEEF);
        cnst = 32'h0000_00A5;
        req_valid = 4'b0100;
        drain("t2b");
        chk("t2b_id", rsp_log[$].id, 2);
        chk("t2b_read", rsp_log[$].rd, 32'h1234_5678);
        chk("t2b_write", rsp_log[$].wr, 32'h0000_00A5);

        // full-width value passes unmodified
        set_pkt(0, 1'b1, 32'hFFFF_FFFF);
        req_valid = 4'b0001;
        drain("fw");
        chk("fw_read", rsp_log[$].rd, 32'h0000_00A5);
        chk("fw_write", rsp_log[$].wr, 32'hFFFF_FFFF);

        // random traffic and backpressure
        oneshot = '0;
        for (int i = 0; i < 300; i++) begin
            req_valid = NR'($urandom);
            req_sel   = NR'($urandom);
            req_pkt   = {$urandom, $urandom, $urandom, $urandom};
            cnst      = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_valid = '0; rsp_ready = 1'b1;
        drain("rand");
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

`ifdef RW_ARB_GRANT_CNT_EN
        // T6: saturating grant counters
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 4'b1000;
        repeat (70000) cyc();
        req_valid = '0;
        drain("t6");
        chk("t6_cnt3", grant_cnt[3*16 +: 16], 16'hFFFF);
        for (int i = 0; i < 3; i++) chk($sformatf("t6_cnt%0d", i), grant_cnt[i*16 +: 16], 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
